// File: rtl/flow_ctrl_param_if.sv
// Handshake and status bundle between the flow controller and its source/destination FIFOs.
// The master modport drives the FIFO side; the slave modport is the controller.
interface flow_ctrl_param_if #(
  parameter int NUM_OUT = 4,
  parameter int DEST_W  = 2
);
  logic                    src_empty;
  logic [DEST_W-1:0]       src_dest;
  logic [NUM_OUT-1:0]      almost_full_in;
  logic [NUM_OUT-1:0]      full_in;
  logic [NUM_OUT-1:0]      almost_empty_in;
  logic [NUM_OUT-1:0]      empty_in;
  logic                    pop;
  logic [NUM_OUT-1:0]      push;
  logic [NUM_OUT-1:0]      continuar;
  logic [NUM_OUT-1:0]      almost_full_out;
  logic [NUM_OUT-1:0]      full_out;
  logic [NUM_OUT-1:0]      almost_empty_out;
  logic [NUM_OUT-1:0]      empty_out;
  logic                    dest_err;
  logic [16*NUM_OUT-1:0]   pause_cnt;

  modport master (
    output src_empty, src_dest, almost_full_in, full_in, almost_empty_in, empty_in,
    input  pop, push, continuar, almost_full_out, full_out, almost_empty_out, empty_out,
    input  dest_err, pause_cnt
  );

  modport slave (
    input  src_empty, src_dest, almost_full_in, full_in, almost_empty_in, empty_in,
    output pop, push, continuar, almost_full_out, full_out, almost_empty_out, empty_out,
    output dest_err, pause_cnt
  );
endinterface

// File: rtl/flow_ctrl_param.sv
// Source->NUM_OUT flow controller: combinational pop, push one cycle after pop, per-channel RUN/PAUSED hysteresis.
// Pops only when the head's channel runs and is not raw-full; optional pause counters under FLOW_CTRL_STATS_EN.
module flow_ctrl_param #(
  parameter int NUM_OUT    = 4,
  parameter int DEST_W     = 2,
  parameter int PAUSE_HOLD = 2
) (
  input logic               clk,
  input logic               rst,
  input logic               enb,
  flow_ctrl_param_if.slave  bus
);
  typedef enum logic {PAUSED = 1'b0, RUN = 1'b1} ch_state_t;

  localparam int              DW1       = DEST_W + 1;
  localparam logic [DEST_W:0] NUM_OUT_W = NUM_OUT[DEST_W:0];
  localparam logic [3:0]      HOLD_INIT = PAUSE_HOLD[3:0];

  ch_state_t          state [NUM_OUT];
  logic [3:0]         hold  [NUM_OUT];
  logic [NUM_OUT-1:0] af_q, f_q, ae_q, e_q;
  logic [NUM_OUT-1:0] push_q, push_nxt, run_vec;
  logic               dest_err_q;
  logic [DEST_W:0]    dest_ext;
  logic               dest_ok, dest_ready, pop_c;

  // Widened index keeps the range check meaningful when 2**DEST_W == NUM_OUT.
  always_comb begin
    dest_ext   = {1'b0, bus.src_dest};
    dest_ok    = dest_ext < NUM_OUT_W;
    dest_ready = 1'b0;
    run_vec    = '0;
    push_nxt   = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      run_vec[i] = (state[i] == RUN);
      if (dest_ext == DW1'(i))
        dest_ready = run_vec[i] & ~bus.full_in[i];
    end
    pop_c = enb & rst & ~bus.src_empty & dest_ok & dest_ready;
    for (int i = 0; i < NUM_OUT; i++)
      push_nxt[i] = pop_c & (dest_ext == DW1'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      af_q       <= '0;
      f_q        <= '0;
      ae_q       <= '0;
      e_q        <= '0;
      push_q     <= '0;
      dest_err_q <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        state[i] <= RUN;
        hold[i]  <= '0;
      end
    end else if (!enb) begin
      push_q <= '0;
    end else begin
      af_q       <= bus.almost_full_in;
      f_q        <= bus.full_in;
      ae_q       <= bus.almost_empty_in;
      e_q        <= bus.empty_in;
      push_q     <= push_nxt;
      dest_err_q <= ~bus.src_empty & ~dest_ok;
      // Hysteresis runs on the registered flags; full blocks resume even when empty is also set.
      for (int i = 0; i < NUM_OUT; i++) begin
        case (state[i])
          RUN: begin
            if (f_q[i] | af_q[i]) begin
              state[i] <= PAUSED;
              hold[i]  <= HOLD_INIT;
            end
          end
          PAUSED: begin
            if ((hold[i] == 4'd0) && (ae_q[i] | e_q[i]) && !f_q[i])
              state[i] <= RUN;
            else if (hold[i] != 4'd0)
              hold[i] <= hold[i] - 4'd1;
          end
          default: state[i] <= RUN;
        endcase
      end
    end
  end

  assign bus.pop              = pop_c;
  assign bus.push             = push_q;
  assign bus.continuar        = run_vec;
  assign bus.almost_full_out  = af_q;
  assign bus.full_out         = f_q;
  assign bus.almost_empty_out = ae_q;
  assign bus.empty_out        = e_q;
  assign bus.dest_err         = dest_err_q;

`ifdef FLOW_CTRL_STATS_EN
  logic [15:0] cnt [NUM_OUT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUT; i++)
        cnt[i] <= '0;
    end else if (enb) begin
      for (int i = 0; i < NUM_OUT; i++)
        if ((state[i] == PAUSED) && (cnt[i] != 16'hFFFF))
          cnt[i] <= cnt[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
    assign bus.pause_cnt[16*g +: 16] = cnt[g];
  end
`else
  assign bus.pause_cnt = '0;
`endif

endmodule

// File: tb/tb_flow_ctrl_param.sv
// Directed bench for flow_ctrl_param: a vector table for pop/push/hysteresis plus hand sequences for reset, enable, dest error, stats.
module tb_flow_ctrl_param;
  logic clk;
  logic rst;
  logic enb;

  flow_ctrl_param_if #(.NUM_OUT(4), .DEST_W(2)) bus4 ();
  flow_ctrl_param_if #(.NUM_OUT(3), .DEST_W(2)) bus3 ();

  flow_ctrl_param #(.NUM_OUT(4), .DEST_W(2), .PAUSE_HOLD(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .enb (enb),
    .bus (bus4)
  );

  flow_ctrl_param #(.NUM_OUT(3), .DEST_W(2), .PAUSE_HOLD(2)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .enb (enb),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       se;
    logic [1:0] dest;
    logic [3:0] af;
    logic [3:0] f;
    logic [3:0] ae;
    logic [3:0] e;
    logic       exp_pop;
    logic [3:0] exp_push;
    logic [3:0] exp_cont;
  } vec_t;

  vec_t tbl [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic se, input logic [1:0] dest, input logic [3:0] af, input logic [3:0] f,
                     input logic [3:0] ae, input logic [3:0] e, input logic p, input logic [3:0] pu,
                     input logic [3:0] c);
    vec_t v;
    v.se = se; v.dest = dest; v.af = af; v.f = f; v.ae = ae; v.e = e;
    v.exp_pop = p; v.exp_push = pu; v.exp_cont = c;
    tbl.push_back(v);
  endtask

  task automatic drive4(input logic se, input logic [1:0] dest, input logic [3:0] af, input logic [3:0] f,
                        input logic [3:0] ae, input logic [3:0] e);
    bus4.src_empty       = se;
    bus4.src_dest        = dest;
    bus4.almost_full_in  = af;
    bus4.full_in         = f;
    bus4.almost_empty_in = ae;
    bus4.empty_in        = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_cnt;

  initial begin
    rst = 1'b0;
    enb = 1'b1;
    drive4(1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    bus3.src_empty = 1'b1; bus3.src_dest = 2'd0;
    bus3.almost_full_in = '0; bus3.full_in = '0; bus3.almost_empty_in = '0; bus3.empty_in = '0;

    // se dest af f ae e | pop push cont
    add(0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 4'b1111);
    add(0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0100, 4'b1111);
    add(0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0100, 4'b1111);
    add(1, 2, 4'h2, 4'h0, 4'h0, 4'h0, 0, 4'b0100, 4'b1111);
    add(1, 2, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 4'b1111);
    add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 4'b1101);
    add(0, 1, 4'h0, 4'h0, 4'h0, 4'h2, 0, 4'b0000, 4'b1101);
    add(0, 1, 4'h0, 4'h0, 4'h0, 4'h2, 0, 4'b0000, 4'b1101);
    add(0, 1, 4'h0, 4'h0, 4'h0, 4'h2, 1, 4'b0000, 4'b1111);
    add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0010, 4'b1111);
    add(0, 3, 4'h0, 4'h8, 4'h0, 4'h0, 0, 4'b0000, 4'b1111);
    add(0, 3, 4'h0, 4'h8, 4'h0, 4'h8, 0, 4'b0000, 4'b1111);
    add(0, 3, 4'h0, 4'h8, 4'h0, 4'h8, 0, 4'b0000, 4'b0111);
    add(0, 3, 4'h0, 4'h8, 4'h0, 4'h8, 0, 4'b0000, 4'b0111);
    add(0, 3, 4'h0, 4'h8, 4'h0, 4'h8, 0, 4'b0000, 4'b0111);
    add(0, 3, 4'h0, 4'h8, 4'h0, 4'h8, 0, 4'b0000, 4'b0111);
    add(0, 3, 4'h0, 4'h0, 4'h0, 4'h8, 0, 4'b0000, 4'b0111);
    add(0, 3, 4'h0, 4'h0, 4'h0, 4'h8, 0, 4'b0000, 4'b0111);
    add(0, 3, 4'h0, 4'h0, 4'h0, 4'h8, 1, 4'b0000, 4'b1111);
    add(1, 3, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b1000, 4'b1111);
    add(0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 4'b1111);
    add(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0001, 4'b1111);
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0001, 4'b1110);

    // Reset: pop is blocked while rst is low, registers come up cleared.
    repeat (2) tick();
    drive4(1'b0, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0);
    #1;
    check("reset_pop", 64'(bus4.pop), 64'd0);
    tick();
    check("reset_push", 64'(bus4.push), 64'd0);
    check("reset_cont", 64'(bus4.continuar), 64'hF);
    check("reset_flags", 64'({bus4.almost_full_out, bus4.full_out, bus4.almost_empty_out, bus4.empty_out}), 64'd0);
    check("reset_dest_err", 64'(bus4.dest_err), 64'd0);
    check("reset_pause_cnt", bus4.pause_cnt, 64'd0);
    rst = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      drive4(tbl[k].se, tbl[k].dest, tbl[k].af, tbl[k].f, tbl[k].ae, tbl[k].e);
      #1;
      check($sformatf("row%0d_pop", k), 64'(bus4.pop), 64'(tbl[k].exp_pop));
      check($sformatf("row%0d_push", k), 64'(bus4.push), 64'(tbl[k].exp_push));
      check($sformatf("row%0d_cont", k), 64'(bus4.continuar), 64'(tbl[k].exp_cont));
      tick();
    end

    // Reset with a pop in flight drops the push and releases the paused channel 0.
    drive4(1'b0, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0);
    #1;
    check("midrst_pop_before", 64'(bus4.pop), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_pop_forced", 64'(bus4.pop), 64'd0);
    tick();
    check("midrst_push", 64'(bus4.push), 64'd0);
    check("midrst_cont", 64'(bus4.continuar), 64'hF);
    rst = 1'b1;

    // enb low: pop blocked, push forced low, flags and FSM frozen.
    drive4(1'b0, 2'd2, 4'h1, 4'h0, 4'h0, 4'h0);
    tick();
    check("enb_pre_push", 64'(bus4.push), 64'b0100);
    check("enb_pre_afo", 64'(bus4.almost_full_out), 64'b0001);
    enb = 1'b0;
    drive4(1'b0, 2'd2, 4'h0, 4'b1011, 4'h0, 4'hF);
    #1;
    check("enb_pop", 64'(bus4.pop), 64'd0);
    for (int n = 0; n < 2; n++) begin
      tick();
      check($sformatf("enb%0d_push", n), 64'(bus4.push), 64'd0);
      check($sformatf("enb%0d_afo", n), 64'(bus4.almost_full_out), 64'b0001);
      check($sformatf("enb%0d_fo", n), 64'(bus4.full_out), 64'd0);
      check($sformatf("enb%0d_eo", n), 64'(bus4.empty_out), 64'd0);
      check($sformatf("enb%0d_cont", n), 64'(bus4.continuar), 64'hF);
    end
    enb = 1'b1;
    drive4(1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    check("enb_resume_cont", 64'(bus4.continuar), 64'b1110);

    // Destination beyond NUM_OUT on the 3-channel instance.
    bus3.src_empty = 1'b0;
    bus3.src_dest  = 2'd3;
    #1;
    check("derr_pop", 64'(bus3.pop), 64'd0);
    check("derr_first", 64'(bus3.dest_err), 64'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("derr%0d", n), 64'(bus3.dest_err), 64'd1);
      check($sformatf("derr%0d_pop", n), 64'(bus3.pop), 64'd0);
    end
    bus3.src_dest = 2'd2;
    #1;
    check("derr_valid_pop", 64'(bus3.pop), 64'd1);
    tick();
    check("derr_clear", 64'(bus3.dest_err), 64'd0);
    check("derr_push", 64'(bus3.push), 64'b100);
    bus3.src_empty = 1'b1;

    // Pause statistics on channel 0.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("stats_reset", bus4.pause_cnt, 64'd0);
    drive4(1'b1, 2'd0, 4'h0, 4'h1, 4'h0, 4'h0);
    repeat (2) tick();
    check("stats_paused", 64'(bus4.continuar[0]), 64'd0);
    repeat (10) tick();
`ifdef FLOW_CTRL_STATS_EN
    exp_cnt = 16'd10;
`else
    exp_cnt = 16'd0;
`endif
    check("stats_cnt0", 64'(bus4.pause_cnt[15:0]), 64'(exp_cnt));
    check("stats_cnt_others", 64'(bus4.pause_cnt[63:16]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
